// File: rtl/forward_hazard_unit_pkg.sv
// Shared types for the EX operand forwarding / load-use hazard unit.
// Select encodings driven to the EX operand muxes, plus the shadow-pipeline slot record.
package forward_hazard_unit_pkg;

  localparam int REG_AW = 3;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/forward_hazard_unit_if.sv
// Decode-side inputs and EX-side selects of the forwarding unit, with shadow-slot visibility.
// master = pipeline/decode side, slave = forward_hazard_unit.
interface forward_hazard_unit_if #(
  parameter int CNT_W = 16
);
  import forward_hazard_unit_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_inport;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              freeze;

  logic [1:0]        Forward1Sel;
  logic [1:0]        Forward2Sel;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;
  slot_t             pipe_e;
  slot_t             pipe_m;
  slot_t             pipe_w;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_inport,
           id_rd, id_reg_write, id_mem_read, flush, freeze,
    input  Forward1Sel, Forward2Sel, stall, stall_count, pipe_e, pipe_m, pipe_w
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_inport,
           id_rd, id_reg_write, id_mem_read, flush, freeze,
    output Forward1Sel, Forward2Sel, stall, stall_count, pipe_e, pipe_m, pipe_w
  );

endinterface

// File: rtl/forward_hazard_unit_fwd_select_cmp.sv
// Per-source forward select: newest non-load producer in E wins, else any producer in M.
// Purely combinational; no state, no backpressure.
module fwd_select_cmp
  import forward_hazard_unit_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic              src_use,
  input  slot_t             e_slot,
  input  slot_t             m_slot,
  output logic [1:0]        sel
);

  logic e_hit;
  logic m_hit;

  // A load in M has its data at MEM/WB by the time the consumer is in EX, so its type is irrelevant.
  logic unused_m_mem_read;
  assign unused_m_mem_read = m_slot.mem_read;

  always_comb begin
    e_hit = src_use & e_slot.valid & e_slot.reg_write & ~e_slot.mem_read & (e_slot.rd == rs);
    m_hit = src_use & m_slot.valid & m_slot.reg_write & (m_slot.rd == rs);
    sel   = FWD_REGFILE;
    if (e_hit) begin
      sel = FWD_EXMEM;
    end else if (m_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// EX forwarding-select generator and load-use stall unit; selects registered (valid in the EX cycle), stall combinational.
// freeze holds every slot, select and the counter; flush beats load-use; stall inserts one bubble.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic                  clk,
  input  logic                  reset,
  forward_hazard_unit_if.slave  bus
);

  slot_t            e_q, e_d;
  slot_t            m_q, m_d;
  slot_t            w_q, w_d;
  slot_t            dec_slot;
  logic [1:0]       fwd1_q, fwd1_d;
  logic [1:0]       fwd2_q, fwd2_d;
  logic [1:0]       fwd1_calc;
  logic [1:0]       fwd2_calc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             use_rs1_eff;
  logic             load_use;
  logic             stall_int;

  // IN takes op1 from the inport, so rs1 neither forwards nor creates a dependency.
  always_comb begin
    use_rs1_eff = bus.id_use_rs1 & ~bus.id_inport;
    load_use    = bus.id_valid & e_q.valid & e_q.mem_read & e_q.reg_write &
                  ((use_rs1_eff & (bus.id_rs1 == e_q.rd)) |
                   (bus.id_use_rs2 & (bus.id_rs2 == e_q.rd)));
    stall_int   = load_use & ~bus.flush & ~bus.freeze & ~reset;
    dec_slot    = '{valid:     bus.id_valid,
                    rd:        bus.id_rd,
                    reg_write: bus.id_reg_write,
                    mem_read:  bus.id_mem_read};
  end

  fwd_select_cmp u_cmp_rs1 (
    .rs      (bus.id_rs1),
    .src_use (use_rs1_eff),
    .e_slot  (e_q),
    .m_slot  (m_q),
    .sel     (fwd1_calc)
  );

  fwd_select_cmp u_cmp_rs2 (
    .rs      (bus.id_rs2),
    .src_use (bus.id_use_rs2),
    .e_slot  (e_q),
    .m_slot  (m_q),
    .sel     (fwd2_calc)
  );

  always_comb begin
    e_d    = e_q;
    m_d    = m_q;
    w_d    = w_q;
    fwd1_d = fwd1_q;
    fwd2_d = fwd2_q;
    cnt_d  = cnt_q;
    if (!bus.freeze) begin
      m_d = e_q;
      w_d = m_q;
      if (bus.flush || stall_int) begin
        e_d    = SLOT_BUBBLE;
        fwd1_d = FWD_REGFILE;
        fwd2_d = FWD_REGFILE;
        if (stall_int && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        e_d    = dec_slot;
        fwd1_d = fwd1_calc;
        fwd2_d = fwd2_calc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q    <= SLOT_BUBBLE;
      m_q    <= SLOT_BUBBLE;
      w_q    <= SLOT_BUBBLE;
      fwd1_q <= FWD_REGFILE;
      fwd2_q <= FWD_REGFILE;
      cnt_q  <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.Forward1Sel = fwd1_q;
  assign bus.Forward2Sel = fwd2_q;
  assign bus.stall       = stall_int;
  assign bus.stall_count = cnt_q;
  assign bus.pipe_e      = e_q;
  assign bus.pipe_m      = m_q;
  assign bus.pipe_w      = w_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: instruction-level pipeline model checked every cycle plus directed literals.
module tb_forward_hazard_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  forward_hazard_unit_if #(.CNT_W(CNT_W)) bus ();

  forward_hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } ent_t;

  ent_t pe, pm, pw;
  int   ef1, ef2, ecnt;
  bit   model_ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input ent_t e);
    logic [2:0] r;
    r = 3'(e.rd);
    return {26'd0, e.v, r, e.rw, e.mr};
  endfunction

  // Which older instruction will hold the newest copy of rs when the consumer reaches EX.
  function automatic int pick(input int rs, input bit use_s);
    if (!use_s) return 0;
    if (pe.v && pe.rw && !pe.mr && pe.rd == rs) return 1;
    if (pm.v && pm.rw && pm.rd == rs) return 2;
    return 0;
  endfunction

  function automatic bit model_stall();
    bit dep;
    dep = (bus.id_use_rs1 && !bus.id_inport && int'(bus.id_rs1) == pe.rd) ||
          (bus.id_use_rs2 && int'(bus.id_rs2) == pe.rd);
    return bus.id_valid && pe.v && pe.mr && pe.rw && dep && !bus.flush && !bus.freeze && !reset;
  endfunction

  task automatic model_step();
    bit   st;
    int   n1, n2;
    ent_t dec;
    if (reset) begin
      pe = '{default: 0}; pm = '{default: 0}; pw = '{default: 0};
      ef1 = 0; ef2 = 0; ecnt = 0; model_ok = 1'b1;
      return;
    end
    if (bus.freeze) return;
    st  = model_stall();
    n1  = bus.id_inport ? 0 : pick(int'(bus.id_rs1), bus.id_use_rs1);
    n2  = pick(int'(bus.id_rs2), bus.id_use_rs2);
    dec = '{v: bus.id_valid, rd: int'(bus.id_rd), rw: bus.id_reg_write, mr: bus.id_mem_read};
    pw = pm;
    pm = pe;
    if (bus.flush || st) begin
      pe = '{default: 0}; ef1 = 0; ef2 = 0;
      if (st && ecnt < CNT_MAX) ecnt++;
    end else begin
      pe = dec; ef1 = n1; ef2 = n2;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    if (model_ok) begin
      chk("stall",       32'(bus.stall),       32'(model_stall()));
      chk("fwd1",        32'(bus.Forward1Sel), 32'(ef1));
      chk("fwd2",        32'(bus.Forward2Sel), 32'(ef2));
      chk("stall_count", 32'(bus.stall_count), 32'(ecnt));
      chk("slot_e",      32'(bus.pipe_e),      pack(pe));
      chk("slot_m",      32'(bus.pipe_m),      pack(pm));
      chk("slot_w",      32'(bus.pipe_w),      pack(pw));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc();
    sample();
    step();
  endtask

  task automatic drv(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                     input bit inp, input int rd, input bit rw, input bit mr);
    bus.id_valid     = v;
    bus.id_rs1       = 3'(rs1);
    bus.id_rs2       = 3'(rs2);
    bus.id_use_rs1   = u1;
    bus.id_use_rs2   = u2;
    bus.id_inport    = inp;
    bus.id_rd        = 3'(rd);
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
  endtask

  task automatic alu(input int rd, input int rs1, input int rs2);
    drv(1'b1, rs1, rs2, 1'b1, 1'b1, 1'b0, rd, 1'b1, 1'b0);
  endtask

  task automatic ld(input int rd, input int rs1);
    drv(1'b1, rs1, 0, 1'b1, 1'b0, 1'b0, rd, 1'b1, 1'b1);
  endtask

  task automatic in_op(input int rd, input int rs1);
    drv(1'b1, rs1, 0, 1'b1, 1'b0, 1'b1, rd, 1'b1, 1'b0);
  endtask

  task automatic nop();
    drv(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    bit hold;
    model_ok   = 1'b0;
    pe = '{default: 0}; pm = '{default: 0}; pw = '{default: 0};
    ef1 = 0; ef2 = 0; ecnt = 0;
    reset      = 1'b1;
    bus.flush  = 1'b0;
    bus.freeze = 1'b0;
    nop();
    cyc();
    sample();
    chk("rst_fwd1",  32'(bus.Forward1Sel), 32'd0);
    chk("rst_fwd2",  32'(bus.Forward2Sel), 32'd0);
    chk("rst_count", 32'(bus.stall_count), 32'd0);
    chk("rst_stall", 32'(bus.stall),       32'd0);
    chk("rst_e_vld", 32'(bus.pipe_e.valid), 32'd0);
    step();
    reset = 1'b0;

    // ADD R1 ; SUB R2,R1,R3
    alu(1, 2, 3); cyc();
    alu(2, 1, 3); sample(); chk("aa_stall", 32'(bus.stall), 32'd0); step();
    nop(); sample();
    chk("aa_fwd1", 32'(bus.Forward1Sel), 32'd1);
    chk("aa_fwd2", 32'(bus.Forward2Sel), 32'd0);
    step();

    // ADD R1 ; NOP ; AND R4,R1,R1
    alu(1, 2, 3); cyc();
    nop(); cyc();
    alu(4, 1, 1); sample(); chk("gap_stall", 32'(bus.stall), 32'd0); step();
    nop(); sample();
    chk("gap_fwd1", 32'(bus.Forward1Sel), 32'd2);
    chk("gap_fwd2", 32'(bus.Forward2Sel), 32'd2);
    step();

    // LDD R5 ; ADD R6,R5,R2
    ld(5, 0); cyc();
    alu(6, 5, 2); sample(); chk("lu_stall", 32'(bus.stall), 32'd1); step();
    sample();
    chk("lu_bub_stall", 32'(bus.stall),        32'd0);
    chk("lu_bub_fwd1",  32'(bus.Forward1Sel),  32'd0);
    chk("lu_bub_fwd2",  32'(bus.Forward2Sel),  32'd0);
    chk("lu_bub_e_vld", 32'(bus.pipe_e.valid), 32'd0);
    chk("lu_count",     32'(bus.stall_count),  32'd1);
    step();
    nop(); sample();
    chk("lu_fwd1",  32'(bus.Forward1Sel), 32'd2);
    chk("lu_count2", 32'(bus.stall_count), 32'd1);
    step();

    // ADD R1 ; ADD R1 ; OR R7,R1,R3 -- newest producer wins
    alu(1, 2, 3); cyc();
    alu(1, 2, 3); cyc();
    alu(7, 1, 3); cyc();
    nop(); sample(); chk("prio_fwd1", 32'(bus.Forward1Sel), 32'd1); step();

    // ADD R1 ; IN R1
    alu(1, 2, 3); cyc();
    in_op(1, 1); cyc();
    nop(); sample(); chk("in_fwd1", 32'(bus.Forward1Sel), 32'd0); step();

    // flush coinciding with a load-use
    ld(5, 0); cyc();
    alu(6, 5, 2); bus.flush = 1'b1;
    sample(); chk("fl_stall", 32'(bus.stall), 32'd0); step();
    bus.flush = 1'b0; nop(); sample();
    chk("fl_e_vld", 32'(bus.pipe_e.valid), 32'd0);
    chk("fl_count", 32'(bus.stall_count),  32'd1);
    chk("fl_fwd1",  32'(bus.Forward1Sel),  32'd0);
    step();

    // freeze for 3 cycles with a load-use pending
    alu(2, 3, 3); cyc();
    ld(5, 2); cyc();
    alu(6, 5, 2); bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("fz_stall", 32'(bus.stall),           32'd0);
      chk("fz_fwd1",  32'(bus.Forward1Sel),     32'd1);
      chk("fz_e_rd",  32'(bus.pipe_e.rd),       32'd5);
      chk("fz_e_ld",  32'(bus.pipe_e.mem_read), 32'd1);
      step();
    end
    bus.freeze = 1'b0;
    sample(); chk("fz_rel_stall", 32'(bus.stall), 32'd1); step();
    sample();
    chk("fz_after_stall", 32'(bus.stall),       32'd0);
    chk("fz_count",       32'(bus.stall_count), 32'd2);
    step();
    nop(); sample();
    chk("fz_fwd1", 32'(bus.Forward1Sel), 32'd2);
    chk("fz_fwd2", 32'(bus.Forward2Sel), 32'd0);
    step();

    // reset in the middle of a stall
    ld(3, 0); cyc();
    alu(4, 3, 3); sample(); chk("rs_stall", 32'(bus.stall), 32'd1);
    reset = 1'b1; step();
    reset = 1'b0; sample();
    chk("rs_stall0", 32'(bus.stall),        32'd0);
    chk("rs_count",  32'(bus.stall_count),  32'd0);
    chk("rs_fwd1",   32'(bus.Forward1Sel),  32'd0);
    chk("rs_fwd2",   32'(bus.Forward2Sel),  32'd0);
    chk("rs_e_vld",  32'(bus.pipe_e.valid), 32'd0);
    chk("rs_m_vld",  32'(bus.pipe_m.valid), 32'd0);
    chk("rs_w_vld",  32'(bus.pipe_w.valid), 32'd0);
    step();

    // counter saturation
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      ld(5, 0); cyc();
      alu(6, 5, 5); cyc(); cyc();
    end
    nop(); sample(); chk("sat_count", 32'(bus.stall_count), 32'(CNT_MAX)); step();

    // mixed traffic against the model, decode held while stalled or frozen
    hold = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        drv($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        bus.flush  = ($urandom_range(0, 9) == 0);
        bus.freeze = ($urandom_range(0, 7) == 0);
      end else begin
        bus.flush  = 1'b0;
        bus.freeze = ($urandom_range(0, 2) == 0);
      end
      reset = ($urandom_range(0, 149) == 0);
      sample();
      hold = bus.stall || bus.freeze;
      step();
    end
    reset = 1'b0;
    bus.freeze = 1'b0;
    bus.flush  = 1'b0;
    nop(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/forward_hazard_unit.md
Name: forward_hazard_unit

Overview:
- Producer side of the execute-stage operand-select interface. It generates Forward1Sel and Forward2Sel, which the execute stage consumes on its 3:1 operand muxes.
- Tracks destination-register info for the EX, MEM and WB pipeline slots in its own shadow pipeline.
- Detects load-use hazards and issues a one-cycle stall with bubble insertion.
- Sits beside the decode/execute pipeline register and drives the EX stage's forwarding selects cycle-aligned with the instruction entering EX.

Parameters:
- REG_AW, 3, register-address width (8 GPRs).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  decode slot holds a real instruction.
- id_rs1  input  REG_AW  source 1 register of decode instruction.
- id_rs2  input  REG_AW  source 2 register of decode instruction.
- id_use_rs1  input  1  instruction reads rs1.
- id_use_rs2  input  1  instruction reads rs2.
- id_inport  input  1  op1 comes from inport (IN instruction).
- id_rd  input  REG_AW  destination register.
- id_reg_write  input  1  instruction writes rd.
- id_mem_read  input  1  instruction is a load.
- flush  input  1  taken branch resolved in EX; kill decode instruction.
- freeze  input  1  memory busy; whole pipeline holds.
- Forward1Sel  output  2  registered op1 select for EX: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- Forward2Sel  output  2  registered op2 select for EX, same encoding.
- stall  output  1  hold PC and IF/ID; insert bubble into ID/EX.
- stall_count  output  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Internal slots E (instruction in EX), M (in MEM), W (in WB). Each slot holds {valid, rd, reg_write, mem_read}. Reset clears all slots to invalid/zero.
- Reset values: Forward1Sel=00, Forward2Sel=00, stall_count=0. stall is forced 0 while reset=1.
- Hazard detection is combinational on decode inputs vs slot E:
  - load_use = id_valid & E.valid & E.mem_read & E.reg_write & ((id_use_rs1 & ~id_inport & id_rs1==E.rd) | (id_use_rs2 & id_rs2==E.rd)).
  - stall = load_use & ~flush & ~freeze & ~reset.
- Forward select for source s, computed against slots E and M:
  - If id_use_s, E.valid, E.reg_write, ~E.mem_read and E.rd==rs: select 01. E will be in MEM when this instruction is in EX.
  - Else if id_use_s, M.valid, M.reg_write and M.rd==rs: select 10.
  - Else select 00.
  - E has priority over M, because it holds the newest value.
  - Forward1Sel is forced 00 when id_inport=1.
  - Code 11 is never driven.
  - WB-to-decode same-cycle bypass belongs to the register file (write-first), not to this block.
- On each clock edge, in priority order:
  - reset: clear all state.
  - freeze=1: hold all slots, selects and counter.
  - flush=1: E<=bubble, selects<=00, M<=E, W<=M.
  - stall=1: E<=bubble, selects<=00, M<=E, W<=M, stall_count++ (saturates at all-ones).
  - Otherwise: E<=decode info (valid=id_valid), selects<=computed, M<=E, W<=M.
- Latency: selects are registered and valid in the cycle the instruction occupies EX.
- A load-use stall lasts exactly one cycle. On the following cycle the load sits in M and the consumer receives select 10.
- flush and load_use together: flush wins. No stall is asserted and the counter does not increment.
- freeze during a pending load_use: stall stays low while frozen and re-evaluates after release.
- Reset mid-stall: the next cycle shows an empty pipeline, stall=0 and counter=0.
- Bubbles (valid=0) never match. Register R0 is not special.

Decomposition:
- Shared package holds:
  - FWD_REGFILE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - The slot struct typedef {valid, rd, reg_write, mem_read}.
  - REG_AW.
- One natural sub-module: fwd_select_cmp. It is a per-source comparator returning the 2-bit select from (rs, use, E, M) and is instantiated twice.

Test Plan:
- Back-to-back ALU ops: ADD R1 then SUB R2,R1,R3 -> Forward1Sel=01 in SUB's EX cycle, stall=0.
- One intervening instruction: ADD R1, NOP, AND R4,R1,R1 -> Forward1Sel=10 and Forward2Sel=10, stall=0.
- Load-use: LDD R5 then ADD R6,R5,R2 -> stall=1 for exactly one cycle, bubble in EX with selects 00, then ADD in EX with Forward1Sel=10, stall_count=1.
- Priority: ADD R1, ADD R1, OR R7,R1 -> OR gets Forward1Sel=01 (newest), not 10.
- IN R1 after ADD R1 (rs1=R1, id_inport=1) -> Forward1Sel=00. Then flush during a load-use -> stall=0, E becomes bubble, stall_count unchanged.
- freeze=1 for 3 cycles with a load-use pending -> selects and slots held, stall=0. After release, one stall cycle. reset asserted mid-stall -> next cycle all outputs 0.
